access_controller: RTL and testbench

Downstream consumer of the token checker's `valid_out` / `replay_out` pulses. These pulses are generated on the ESP32 byte strobe and are asynchronous to `CLOCK_50`. The block synchronises them into the 50 MHz domain and runs the door-access state machine: timed unlock on a fresh token, timed alarm on a replayed token, and a timed lockout after repeated replays. It also keeps saturating event counters for status readout.

---
 rtl/access_controller.sv | 160 ++++++++++++++++
 tb/tb_access_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/access_controller.sv
// access_controller
//
// Door-access state machine fed by the token checker's valid/replay pulses.
// Those pulses come from the ESP32 byte-strobe domain. Each one passes through
// a two-flop synchroniser into CLOCK_50 and is then reduced to a single-cycle
// rising-edge event.
//
//   IDLE    -> UNLOCK on a fresh token (timed door_unlock)
//   any     -> ALARM  on a replayed token (timed alarm)
//   any     -> LOCKOUT after MAX_REPLAYS consecutive replays (timed lockout)
//
// Handshake note: there is no valid/ready pairing here. valid_in and replay_in
// are free-running asynchronous pulses with no back-pressure. Each pulse must
// stay high >= 2 clocks and low >= 2 clocks. Every rising edge yields exactly
// one event, and that event is always consumed in the cycle it appears.
//
// Ports
//   CLOCK_50      in   system clock, all state on rising edge
//   reset         in   asynchronous, active-high
//   valid_in      in   async pulse: new token accepted
//   replay_in     in   async pulse: replayed token
//   door_unlock   out  lock relay drive, high = unlocked
//   alarm         out  buzzer / red LED (ALARM or LOCKOUT)
//   lockout       out  high while in LOCKOUT
//   accept_count  out  saturating accepted-token count
//   replay_count  out  saturating replay-event count
//   state_dbg     out  current FSM state (0 IDLE, 1 UNLOCK, 2 ALARM, 3 LOCKOUT)
module access_controller #(
    parameter int unsigned UNLOCK_CYCLES  = 150_000_000,
    parameter int unsigned ALARM_CYCLES   = 25_000_000,
    parameter int unsigned MAX_REPLAYS    = 3,
    parameter int unsigned LOCKOUT_CYCLES = 500_000_000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        replay_in,
    output logic        door_unlock,
    output logic        alarm,
    output logic        lockout,
    output logic [15:0] accept_count,
    output logic [15:0] replay_count,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_UNLOCK  = 2'd1,
        ST_ALARM   = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    // Synchronisers and history flops reset high. A level that is already high
    // when reset is released therefore does not look like a rising edge.
    logic valid_s1, valid_s2, valid_h;
    logic replay_s1, replay_s2, replay_h;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            valid_s1  <= 1'b1;
            valid_s2  <= 1'b1;
            valid_h   <= 1'b1;
            replay_s1 <= 1'b1;
            replay_s2 <= 1'b1;
            replay_h  <= 1'b1;
        end else begin
            valid_s1  <= valid_in;
            valid_s2  <= valid_s1;
            valid_h   <= valid_s2;
            replay_s1 <= replay_in;
            replay_s2 <= replay_s1;
            replay_h  <= replay_s2;
        end
    end

    logic valid_ev, replay_ev;
    assign valid_ev  = valid_s2 & ~valid_h;
    assign replay_ev = replay_s2 & ~replay_h;

    state_t      state, nxt_state;
    logic [31:0] timer, nxt_timer;
    logic [7:0]  strike, nxt_strike;
    logic        acc_inc;
    logic        strike_hit;

    assign state_dbg  = state;
    assign strike_hit = (({24'd0, strike} + 32'd1) == MAX_REPLAYS);

    // Next-state decode. A replay always outranks a valid event that arrives
    // in the same cycle. Any event outranks the timer expiring.
    always_comb begin
        nxt_state  = state;
        nxt_timer  = timer;
        nxt_strike = strike;
        acc_inc    = 1'b0;
        case (state)
            ST_LOCKOUT: begin
                // Events are ignored here (replays are still counted below).
                if (timer == 32'd0) begin
                    nxt_state  = ST_IDLE;
                    nxt_strike = 8'd0;
                end else begin
                    nxt_timer = timer - 32'd1;
                end
            end
            default: begin
                if (replay_ev) begin
                    if (strike_hit) begin
                        nxt_state = ST_LOCKOUT;
                        nxt_timer = LOCKOUT_CYCLES - 32'd1;
                    end else begin
                        nxt_state  = ST_ALARM;
                        nxt_timer  = ALARM_CYCLES - 32'd1;
                        nxt_strike = strike + 8'd1;
                    end
                end else if (valid_ev && (state != ST_ALARM)) begin
                    nxt_state  = ST_UNLOCK;
                    nxt_timer  = UNLOCK_CYCLES - 32'd1;
                    nxt_strike = 8'd0;
                    acc_inc    = 1'b1;
                end else if (state != ST_IDLE) begin
                    if (timer == 32'd0) begin
                        nxt_state = ST_IDLE;
                    end else begin
                        nxt_timer = timer - 32'd1;
                    end
                end
            end
        endcase
    end

    // State, timer, counters and Moore outputs. The outputs are decoded from
    // the next state, so they change on the same edge as the state does.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            timer        <= 32'd0;
            strike       <= 8'd0;
            accept_count <= 16'd0;
            replay_count <= 16'd0;
            door_unlock  <= 1'b0;
            alarm        <= 1'b0;
            lockout      <= 1'b0;
        end else begin
            state  <= nxt_state;
            timer  <= nxt_timer;
            strike <= nxt_strike;
            if (acc_inc && (accept_count != 16'hFFFF)) begin
                accept_count <= accept_count + 16'd1;
            end
            if (replay_ev && (replay_count != 16'hFFFF)) begin
                replay_count <= replay_count + 16'd1;
            end
            door_unlock <= (nxt_state == ST_UNLOCK);
            alarm       <= (nxt_state == ST_ALARM) || (nxt_state == ST_LOCKOUT);
            lockout     <= (nxt_state == ST_LOCKOUT);
        end
    end

endmodule

// File: tb/tb_access_controller.sv
// Directed bench for access_controller.
// Parameters: UNLOCK=10, ALARM=5, MAX_REPLAYS=3, LOCKOUT=20.
// Inputs are driven 1 time unit after a rising edge. Outputs are sampled at
// that same point, which is away from the active edge.
module tb_access_controller;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        replay_in;
  logic        door_unlock;
  logic        alarm;
  logic        lockout;
  logic [15:0] accept_count;
  logic [15:0] replay_count;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  access_controller #(
    .UNLOCK_CYCLES(10),
    .ALARM_CYCLES(5),
    .MAX_REPLAYS(3),
    .LOCKOUT_CYCLES(20)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .valid_in(valid_in),
    .replay_in(replay_in),
    .door_unlock(door_unlock),
    .alarm(alarm),
    .lockout(lockout),
    .accept_count(accept_count),
    .replay_count(replay_count),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 CLOCK_50 = ~CLOCK_50;

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic d, input logic a, input logic l);
    chk1({tag, "_door"}, door_unlock, d);
    chk1({tag, "_alarm"}, alarm, a);
    chk1({tag, "_lockout"}, lockout, l);
  endtask

  initial begin
    // Reset with valid_in already high.
    reset = 1'b1;
    valid_in = 1'b1;
    replay_in = 1'b0;
    #2;
    chk_outs("reset", 1'b0, 1'b0, 1'b0);
    chk16("reset_acc", accept_count, 16'd0);
    chk16("reset_rep", replay_count, 16'd0);
    tick(2);
    reset = 1'b0;
    tick(3);
    chk1("held_level_no_event", door_unlock, 1'b0);
    chk16("held_level_acc", accept_count, 16'd0);

    // Test 1: 4-clock pulse, then a full 10-clock unlock.
    valid_in = 1'b0;
    tick(4);
    valid_in = 1'b1;
    tick(2);
    chk1("t1_edge2", door_unlock, 1'b0);
    tick(1);
    chk_outs("t1_rise", 1'b1, 1'b0, 1'b0);
    chk16("t1_acc", accept_count, 16'd1);
    tick(1);
    valid_in = 1'b0;
    tick(8);
    chk1("t1_last_high", door_unlock, 1'b1);
    tick(1);
    chk1("t1_fall", door_unlock, 1'b0);

    // Test 2: a second pulse 6 clocks into UNLOCK extends the unlock.
    valid_in = 1'b1;
    tick(3);
    chk1("t2_rise", door_unlock, 1'b1);
    chk16("t2_acc_a", accept_count, 16'd2);
    valid_in = 1'b0;
    tick(3);
    valid_in = 1'b1;
    tick(2);
    chk1("t2_pre_reload", door_unlock, 1'b1);
    chk16("t2_acc_pre", accept_count, 16'd2);
    tick(1);
    chk1("t2_reload", door_unlock, 1'b1);
    chk16("t2_acc_b", accept_count, 16'd3);
    valid_in = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick(1);
      chk1("t2_hold", door_unlock, 1'b1);
    end
    tick(1);
    chk1("t2_fall", door_unlock, 1'b0);

    // Test 3: a replay during UNLOCK hands over directly to ALARM.
    valid_in = 1'b1;
    tick(3);
    chk1("t3_unlock", door_unlock, 1'b1);
    chk16("t3_acc", accept_count, 16'd4);
    valid_in = 1'b0;
    tick(2);
    replay_in = 1'b1;
    tick(2);
    chk_outs("t3_before", 1'b1, 1'b0, 1'b0);
    tick(1);
    chk_outs("t3_handover", 1'b0, 1'b1, 1'b0);
    chk16("t3_rep", replay_count, 16'd1);
    replay_in = 1'b0;
    tick(4);
    chk1("t3_alarm_last", alarm, 1'b1);
    tick(1);
    chk_outs("t3_alarm_end", 1'b0, 1'b0, 1'b0);

    // Clear the strike with an accepted token, then let the unlock expire.
    valid_in = 1'b1;
    tick(3);
    chk16("t4_pre_acc", accept_count, 16'd5);
    valid_in = 1'b0;
    tick(10);
    chk1("t4_pre_idle", door_unlock, 1'b0);

    // Test 4: three replays 8 clocks apart lead to LOCKOUT.
    replay_in = 1'b1;
    tick(3);
    chk_outs("t4_r1", 1'b0, 1'b1, 1'b0);
    chk16("t4_r1_cnt", replay_count, 16'd2);
    replay_in = 1'b0;
    tick(5);
    chk1("t4_r1_end", alarm, 1'b0);
    replay_in = 1'b1;
    tick(3);
    chk_outs("t4_r2", 1'b0, 1'b1, 1'b0);
    chk16("t4_r2_cnt", replay_count, 16'd3);
    replay_in = 1'b0;
    tick(5);
    chk1("t4_r2_end", alarm, 1'b0);
    replay_in = 1'b1;
    tick(2);
    chk1("t4_r3_before", lockout, 1'b0);
    tick(1);
    chk_outs("t4_lockout", 1'b0, 1'b1, 1'b1);
    chk16("t4_r3_cnt", replay_count, 16'd4);
    replay_in = 1'b0;
    // A valid token during lockout is ignored.
    tick(2);
    valid_in = 1'b1;
    tick(3);
    valid_in = 1'b0;
    chk16("t4_lock_valid_acc", accept_count, 16'd5);
    chk_outs("t4_lock_valid", 1'b0, 1'b1, 1'b1);
    // A replay during lockout is counted but does not extend the lockout.
    tick(2);
    replay_in = 1'b1;
    tick(3);
    replay_in = 1'b0;
    chk16("t4_lock_rep_cnt", replay_count, 16'd5);
    tick(9);
    chk_outs("t4_lock_last", 1'b0, 1'b1, 1'b1);
    tick(1);
    chk_outs("t4_lock_end", 1'b0, 1'b0, 1'b0);
    // Strike was cleared on exit, so the next replay gives ALARM, not LOCKOUT.
    replay_in = 1'b1;
    tick(3);
    chk_outs("t4_post_alarm", 1'b0, 1'b1, 1'b0);
    chk16("t4_post_cnt", replay_count, 16'd6);
    replay_in = 1'b0;
    tick(5);
    chk1("t4_post_end", alarm, 1'b0);

    // Reset back to zero counts (the clock keeps running).
    reset = 1'b1;
    #1;
    chk16("rst2_acc", accept_count, 16'd0);
    chk16("rst2_rep", replay_count, 16'd0);
    tick(1);
    reset = 1'b0;
    tick(3);

    // Test 5: simultaneous valid and replay; the replay wins.
    valid_in = 1'b1;
    replay_in = 1'b1;
    tick(3);
    chk_outs("t5_both", 1'b0, 1'b1, 1'b0);
    chk16("t5_acc", accept_count, 16'd0);
    chk16("t5_rep", replay_count, 16'd1);
    valid_in = 1'b0;
    replay_in = 1'b0;
    tick(5);
    chk1("t5_end", alarm, 1'b0);

    // Test 6: saturate accept_count, then reset asynchronously mid-UNLOCK.
    for (int i = 0; i < 65536; i++) begin
      valid_in = 1'b1;
      tick(1);
      valid_in = 1'b0;
      tick(1);
    end
    tick(3);
    chk16("t6_full", accept_count, 16'hFFFF);
    chk1("t6_unlock", door_unlock, 1'b1);
    valid_in = 1'b1;
    tick(1);
    valid_in = 1'b0;
    tick(3);
    chk16("t6_saturate", accept_count, 16'hFFFF);
    chk1("t6_unlock2", door_unlock, 1'b1);
    reset = 1'b1;
    #1;
    chk_outs("t6_async_reset", 1'b0, 1'b0, 1'b0);
    chk16("t6_rst_acc", accept_count, 16'd0);
    chk16("t6_rst_rep", replay_count, 16'd0);
    tick(1);
    reset = 1'b0;

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
